// File: rtl/glitch_sequencer.sv
// Trigger-to-glitch timing controller driving en/mode of the clock-glitch core.
// Optional GLITCH_TRIG_SYNC_EN adds a 2-flop trigger synchroniser (+2 cycles).
module glitch_sequencer #(
    parameter int DLY_W = 16,
    parameter int WID_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [DLY_W-1:0] cfg_delay,
    input  logic [WID_W-1:0] cfg_width,
    input  logic [WID_W-1:0] cfg_gap,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [7:0]       cfg_mode,
    input  logic             arm,
    input  logic             abort,
    input  logic             trigger,
    output logic             en,
    output logic [7:0]       mode,
    output logic             armed,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {IDLE, ARMED, DELAY, GLITCH, GAP} state_t;

    localparam logic [DLY_W-1:0] D1 = DLY_W'(1);
    localparam logic [WID_W-1:0] W1 = WID_W'(1);
    localparam logic [CNT_W-1:0] C1 = CNT_W'(1);

    state_t             state_q, state_d;
    logic [DLY_W-1:0]   dly_q, dcnt_q, dcnt_d;
    logic [WID_W-1:0]   wid_q, gap_q;
    logic [WID_W-1:0]   wcnt_q, wcnt_d, gcnt_q, gcnt_d;
    logic [CNT_W-1:0]   cnt_q, pcnt_q, pcnt_d;
    logic [7:0]         mode_q;
    logic               en_q, en_d, busy_q, busy_d;
    logic               armed_q, armed_d, done_q, done_d;
    logic               trig_s, trig_prev_q, trig_ev, load;

`ifdef GLITCH_TRIG_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], trigger};
    end
    assign trig_s = sync_q[1];
`else
    assign trig_s = trigger;
`endif

    assign trig_ev = trig_s & ~trig_prev_q;
    assign load    = (state_q == IDLE) & arm & ~abort;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        wcnt_d  = wcnt_q;
        gcnt_d  = gcnt_q;
        pcnt_d  = pcnt_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arm) state_d = ARMED;
                end
                ARMED: begin
                    if (trig_ev) begin
                        state_d = DELAY;
                        dcnt_d  = dly_q;
                    end
                end
                DELAY: begin
                    if (dcnt_q != '0) begin
                        dcnt_d = dcnt_q - D1;
                    end else begin
                        state_d = GLITCH;
                        wcnt_d  = wid_q - W1;
                        pcnt_d  = cnt_q - C1;
                    end
                end
                GLITCH: begin
                    if (wcnt_q != '0) begin
                        wcnt_d = wcnt_q - W1;
                    end else if (pcnt_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        pcnt_d = pcnt_q - C1;
                        // zero gap keeps en high across pulse boundaries
                        if (gap_q != '0) begin
                            state_d = GAP;
                            gcnt_d  = gap_q - W1;
                        end else begin
                            wcnt_d = wid_q - W1;
                        end
                    end
                end
                GAP: begin
                    if (gcnt_q != '0) begin
                        gcnt_d = gcnt_q - W1;
                    end else begin
                        state_d = GLITCH;
                        wcnt_d  = wid_q - W1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        en_d    = (state_d == GLITCH);
        armed_d = (state_d == ARMED);
        busy_d  = (state_d == DELAY) || (state_d == GLITCH) ||
                  (state_d == GAP);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q      <= '0;
            wcnt_q      <= '0;
            gcnt_q      <= '0;
            pcnt_q      <= '0;
            dly_q       <= '0;
            wid_q       <= W1;
            gap_q       <= '0;
            cnt_q       <= C1;
            mode_q      <= '0;
            trig_prev_q <= 1'b0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            armed_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            dcnt_q      <= dcnt_d;
            wcnt_q      <= wcnt_d;
            gcnt_q      <= gcnt_d;
            pcnt_q      <= pcnt_d;
            trig_prev_q <= trig_s;
            en_q        <= en_d;
            busy_q      <= busy_d;
            armed_q     <= armed_d;
            done_q      <= done_d;
            if (load) begin
                dly_q  <= cfg_delay;
                wid_q  <= (cfg_width == '0) ? W1 : cfg_width;
                gap_q  <= cfg_gap;
                cnt_q  <= (cfg_count == '0) ? C1 : cfg_count;
                mode_q <= cfg_mode;
            end
        end
    end

    assign en    = en_q;
    assign mode  = mode_q;
    assign armed = armed_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer with a timeline-arithmetic reference model.
module tb_glitch_sequencer;

`ifdef GLITCH_TRIG_SYNC_EN
    localparam int LAG = 2;
`else
    localparam int LAG = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cfg_delay = '0, cfg_width = '0, cfg_gap = '0;
    logic [7:0]  cfg_count = '0, cfg_mode = '0;
    logic        arm = 1'b0, abort = 1'b0, trigger = 1'b0;
    logic        en, armed, busy, done;
    logic [7:0]  mode;

    int tot = 0;
    int bad = 0;

    glitch_sequencer dut (
        .clk_in(clk), .rst_n(rst_n),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width),
        .cfg_gap(cfg_gap), .cfg_count(cfg_count),
        .cfg_mode(cfg_mode), .arm(arm), .abort(abort),
        .trigger(trigger), .en(en), .mode(mode),
        .armed(armed), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        tot++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the sequence is a timeline relative to the trigger edge.
    int   cyc = 0, mst = 0, md = 0, mw = 1, mg = 0, mc = 1, mT = 0;
    int   off = 0, span = 0, per = 1;
    logic [2:0] h = '0;
    logic ev = 1'b0;
    logic [7:0] emode = '0;
    logic een = 0, edone = 0, ebusy = 0, earmed = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst = 0; h = '0; emode = '0; cyc = 0;
            een = 0; edone = 0; ebusy = 0; earmed = 0;
        end else begin
            cyc++;
            ev = (LAG == 0) ? (trigger && !h[0]) : (h[1] && !h[2]);
            h = {h[1:0], trigger};
            if (abort) begin
                mst = 0;
            end else if (mst == 0) begin
                if (arm) begin
                    md = int'(cfg_delay);
                    mw = (cfg_width == 0) ? 1 : int'(cfg_width);
                    mg = int'(cfg_gap);
                    mc = (cfg_count == 0) ? 1 : int'(cfg_count);
                    emode = cfg_mode;
                    mst = 1;
                end
            end else if (mst == 1) begin
                if (ev) begin
                    mst = 2;
                    mT = cyc;
                end
            end
            een = 0; edone = 0; ebusy = 0;
            earmed = (mst == 1);
            if (mst == 2) begin
                off  = cyc - (mT + 1 + md);
                span = mc * mw + (mc - 1) * mg;
                per  = mw + mg;
                if (off == span) begin
                    edone = 1;
                    mst = 0;
                end else begin
                    ebusy = 1;
                    if (off >= 0) een = ((off % per) < mw);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("en", en, een);
        chk("done", done, edone);
        chk("busy", busy, ebusy);
        chk("armed", armed, earmed);
        chk("mode", mode, emode);
    end

    task automatic arm_cfg(input int d, input int w, input int g,
                           input int c, input logic [7:0] m);
        cfg_delay = 16'(d); cfg_width = 16'(w); cfg_gap = 16'(g);
        cfg_count = 8'(c); cfg_mode = m;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic fire(input int nwin, input int arm_at, input int abort_at,
                        output int highs, output int first, output int dones,
                        output int done_at, output logic [63:0] pat);
        trigger = 1'b1;
        highs = 0; first = -1; dones = 0; done_at = -1; pat = '0;
        for (int j = 0; j < nwin; j++) begin
            @(negedge clk);
            if (j < 64) pat[j] = en;
            if (en) begin
                highs++;
                if (first < 0) first = j;
            end
            if (done) begin
                dones++;
                done_at = j;
            end
            arm = (j == arm_at);
            abort = (j == abort_at);
            if (j == arm_at) begin
                cfg_delay = 0; cfg_width = 1; cfg_gap = 0;
                cfg_count = 7; cfg_mode = 8'hAA;
            end
        end
        arm = 1'b0;
        abort = 1'b0;
        trigger = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    int hi, fst, dn, dat;
    logic [63:0] pt;

    initial begin
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            trigger = ~trigger;
        end
        chk("rst_en", en, 0);
        chk("rst_mode", mode, 0);
        chk("rst_armed", armed, 0);
        chk("rst_busy", busy, 0);
        trigger = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        fire(12, -1, -1, hi, fst, dn, dat, pt);
        chk("noarm_highs", hi, 0);

        arm_cfg(5, 3, 0, 1, 8'h08);
        fire(16, -1, -1, hi, fst, dn, dat, pt);
        chk("single_first", fst, 6 + LAG);
        chk("single_highs", hi, 3);
        chk("single_dones", dn, 1);
        chk("single_done_at", dat, 9 + LAG);
        chk("single_mode", mode, 8'h08);

        arm_cfg(0, 2, 4, 3, 8'h21);
        fire(24, -1, -1, hi, fst, dn, dat, pt);
        chk("train_pat", (pt >> LAG) & 64'hFFFF, 24966);
        chk("train_done_at", dat, 15 + LAG);

        arm_cfg(0, 0, 0, 0, 8'h01);
        fire(10, -1, -1, hi, fst, dn, dat, pt);
        chk("zero_highs", hi, 1);
        chk("zero_dones", dn, 1);

        arm_cfg(0, 4, 0, 2, 8'h02);
        fire(16, -1, -1, hi, fst, dn, dat, pt);
        chk("contig_highs", hi, 8);
        chk("contig_pat", (pt >> (1 + LAG)) & 64'hFFFF, 16'h00FF);

        arm_cfg(0, 10, 0, 1, 8'h66);
        fire(20, -1, 2 + LAG, hi, fst, dn, dat, pt);
        chk("abort_highs", hi, 2);
        chk("abort_dones", dn, 0);
        chk("abort_en_next", pt[3 + LAG], 0);
        chk("abort_mode", mode, 8'h66);

        arm_cfg(1, 1, 0, 1, 8'h77);
        fire(10, -1, -1, hi, fst, dn, dat, pt);
        chk("rearm_highs", hi, 1);
        chk("rearm_first", fst, 2 + LAG);

        trigger = 1'b1;
        repeat (2) @(negedge clk);
        arm_cfg(1, 2, 0, 1, 8'h44);
        arm_cfg(0, 7, 0, 1, 8'h45);
        repeat (6) @(negedge clk);
        chk("held_armed", armed, 1);
        chk("held_en", en, 0);
        trigger = 1'b0;
        @(negedge clk);
        fire(12, -1, -1, hi, fst, dn, dat, pt);
        chk("held_highs", hi, 2);
        chk("held_first", fst, 2 + LAG);
        chk("held_mode", mode, 8'h44);

        arm_cfg(2, 5, 1, 2, 8'h55);
        fire(30, 4, -1, hi, fst, dn, dat, pt);
        chk("busyarm_highs", hi, 10);
        chk("busyarm_done_at", dat, 14 + LAG);
        chk("busyarm_mode", mode, 8'h55);

        arm_cfg(0, 20, 0, 1, 8'h33);
        trigger = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_en_before", en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_en", en, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        trigger = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
